// File: rtl/i2s_rx.sv
// ---------------------------------------------------------------------------
// i2s_rx - I2S serial receiver.
//
// Samples sdata_in on every rising sclk_in edge. lrck_in splits the stream
// into words (0 = left slot, 1 = right slot). Each completed word is presented
// MSB-aligned on its channel register, together with a one-cycle strobe.
//
// Ports
//   sclk_in          in   1            serial bit clock, all logic on posedge
//   rst              in   1            synchronous active-high reset
//   lrck_in          in   1            word select, 0 = left, 1 = right
//   sdata_in         in   1            serial data, MSB first, I2S delayed format
//   pldata_out       out  PDATA_WIDTH  last completed left word, MSB-aligned
//   prdata_out       out  PDATA_WIDTH  last completed right word, MSB-aligned
//   lvalid_out       out  1            strobe: pldata_out just updated
//   rvalid_out       out  1            strobe: prdata_out just updated
//   frame_valid_out  out  1            strobe with rvalid_out when the L/R pair
//                                      is complete
// ---------------------------------------------------------------------------
module i2s_rx #(
    parameter int PDATA_WIDTH = 32
) (
    input  logic                   sclk_in,
    input  logic                   rst,
    input  logic                   lrck_in,
    input  logic                   sdata_in,
    output logic [PDATA_WIDTH-1:0] pldata_out,
    output logic [PDATA_WIDTH-1:0] prdata_out,
    output logic                   lvalid_out,
    output logic                   rvalid_out,
    output logic                   frame_valid_out
);

    // The counter must be able to hold PDATA_WIDTH itself: that value marks
    // "assembly register full, drop any further bits of this word".
    localparam int             CNT_W   = $clog2(PDATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PDATA_WIDTH);

    logic                   lrck_q,   lrck_d;
    logic                   synced_q, synced_d;
    logic                   lseen_q,  lseen_d;
    logic [CNT_W-1:0]       cnt_q,    cnt_d;
    logic [PDATA_WIDTH-1:0] asm_q,    asm_d;
    logic [PDATA_WIDTH-1:0] pldata_q, pldata_d;
    logic [PDATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                   lvalid_q, lvalid_d;
    logic                   rvalid_q, rvalid_d;
    logic                   frame_q,  frame_d;

    logic                   boundary;
    logic [PDATA_WIDTH-1:0] word;

    always_comb begin
        boundary = (lrck_in != lrck_q);

        // Current assembly plus the bit sampled on this edge. Bit k of the
        // word lands at position PDATA_WIDTH-1-k; once the counter has
        // saturated no position matches and the bit is dropped.
        word = asm_q;
        for (int i = 0; i < PDATA_WIDTH; i++) begin
            if (cnt_q == CNT_W'(PDATA_WIDTH - 1 - i)) begin
                word[i] = sdata_in;
            end
        end

        lrck_d   = lrck_in;
        synced_d = synced_q;
        lseen_d  = lseen_q;
        cnt_d    = cnt_q;
        asm_d    = asm_q;
        pldata_d = pldata_q;
        prdata_d = prdata_q;
        lvalid_d = 1'b0;
        rvalid_d = 1'b0;
        frame_d  = 1'b0;

        if (boundary) begin
            // This edge carries the LSB of the word belonging to lrck_q.
            asm_d    = '0;
            cnt_d    = '0;
            synced_d = 1'b1;
            if (!synced_q) begin
                // First boundary after reset: the partial word is discarded.
                lseen_d = 1'b0;
            end else if (!lrck_q) begin
                pldata_d = word;
                lvalid_d = 1'b1;
                lseen_d  = 1'b1;
            end else begin
                prdata_d = word;
                rvalid_d = 1'b1;
                frame_d  = lseen_q;
                lseen_d  = 1'b0;
            end
        end else begin
            asm_d = word;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sclk_in) begin
        if (rst) begin
            lrck_q   <= 1'b0;
            synced_q <= 1'b0;
            lseen_q  <= 1'b0;
            cnt_q    <= '0;
            asm_q    <= '0;
            pldata_q <= '0;
            prdata_q <= '0;
            lvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            lrck_q   <= lrck_d;
            synced_q <= synced_d;
            lseen_q  <= lseen_d;
            cnt_q    <= cnt_d;
            asm_q    <= asm_d;
            pldata_q <= pldata_d;
            prdata_q <= prdata_d;
            lvalid_q <= lvalid_d;
            rvalid_q <= rvalid_d;
            frame_q  <= frame_d;
        end
    end

    assign pldata_out      = pldata_q;
    assign prdata_out      = prdata_q;
    assign lvalid_out      = lvalid_q;
    assign rvalid_out      = rvalid_q;
    assign frame_valid_out = frame_q;

endmodule

// File: tb/tb_i2s_rx.sv
// ---------------------------------------------------------------------------
// tb_i2s_rx - bench for i2s_rx. Two instances share the serial inputs:
// dut_a with a 32-bit parallel word, dut_b with a 24-bit one (truncation).
// Stimulus is generated word by word; the reference model works on whole
// words (channel, value, bit count) and predicts the committed words.
// ---------------------------------------------------------------------------
module tb_i2s_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lrck = 1'b0;
    logic        sdata = 1'b0;

    logic [31:0] pldata_a, prdata_a;
    logic        lvalid_a, rvalid_a, frame_a;
    logic [23:0] pldata_b, prdata_b;
    logic        lvalid_b, rvalid_b, frame_b;

    always #5 clk = ~clk;

    i2s_rx #(.PDATA_WIDTH(32)) dut_a (
        .sclk_in(clk), .rst(rst), .lrck_in(lrck), .sdata_in(sdata),
        .pldata_out(pldata_a), .prdata_out(prdata_a),
        .lvalid_out(lvalid_a), .rvalid_out(rvalid_a), .frame_valid_out(frame_a)
    );

    i2s_rx #(.PDATA_WIDTH(24)) dut_b (
        .sclk_in(clk), .rst(rst), .lrck_in(lrck), .sdata_in(sdata),
        .pldata_out(pldata_b), .prdata_out(prdata_b),
        .lvalid_out(lvalid_b), .rvalid_out(rvalid_b), .frame_valid_out(frame_b)
    );

    int checks = 0;
    int errors = 0;

    // Observations of dut_a, captured mid-cycle.
    logic [31:0] obs_l[$];
    logic [31:0] obs_lpr[$];   // prdata at each left strobe
    logic [31:0] obs_r[$];
    logic        obs_f[$];     // frame_valid at each right strobe
    int          fhigh  = 0;   // cycles with frame_valid high
    int          lcnt_b = 0;   // left strobes of dut_b

    always @(negedge clk) begin
        if (lvalid_a) begin
            obs_l.push_back(pldata_a);
            obs_lpr.push_back(prdata_a);
        end
        if (rvalid_a) begin
            obs_r.push_back(prdata_a);
            obs_f.push_back(frame_a);
        end
        if (frame_a) fhigh++;
        if (lvalid_b) lcnt_b++;
    end

    // Reference model state (word level).
    logic [31:0] exp_l[$];
    logic [31:0] exp_r[$];
    logic        exp_f[$];
    logic        m_synced, m_lseen, cur_lr, pend;
    logic        prev_c;
    logic [63:0] prev_v;
    int          prev_n;
    int          s_l, s_r, s_fh, s_b;

    // First n bits of v (MSB first) placed MSB-aligned in a w-bit word.
    function automatic logic [31:0] align(input logic [63:0] v, input int n, input int w);
        logic [63:0] m;
        logic [63:0] r;
        m = v & ((64'd1 << n) - 64'd1);
        if (n >= w) r = m >> (n - w);
        else        r = m << (w - n);
        if (w < 32) r = r & ((64'd1 << w) - 64'd1);
        return r[31:0];
    endfunction

    task automatic drive(input logic lr, input logic sd);
        lrck  = lr;
        sdata = sd;
        @(posedge clk);
        #1;
    endtask

    task automatic commit_prev();
        if (!prev_c) begin
            exp_l.push_back(align(prev_v, prev_n, 32));
            m_lseen = 1'b1;
        end else begin
            exp_r.push_back(align(prev_v, prev_n, 32));
            exp_f.push_back(m_lseen);
            m_lseen = 1'b0;
        end
    endtask

    task automatic boundary_edge(input logic c);
        drive(c, pend);
        if (!m_synced) begin
            m_synced = 1'b1;
            m_lseen  = 1'b0;
        end else begin
            commit_prev();
        end
        cur_lr = c;
    endtask

    // Send one word on channel c (must differ from the current channel).
    // Its LSB stays pending until the next word's first edge.
    task automatic send_word(input logic c, input logic [63:0] v, input int n);
        boundary_edge(c);
        prev_c = c;
        prev_v = v;
        prev_n = n;
        for (int k = 0; k < n - 1; k++) drive(c, v[n-1-k]);
        pend = v[0];
    endtask

    task automatic flush();
        boundary_edge(~cur_lr);
        @(negedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_synced = 1'b0;
        m_lseen  = 1'b0;
        cur_lr   = 1'b0;
        pend     = 1'b0;
        exp_l.delete();
        exp_r.delete();
        exp_f.delete();
        s_l  = obs_l.size();
        s_r  = obs_r.size();
        s_fh = fhigh;
        s_b  = lcnt_b;
    endtask

    task automatic begin_test();
        rst = 1'b1;
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        begin_test();
        checks++;
        if ({pldata_a, prdata_a} !== 64'd0) begin
            errors++;
            $display("FAIL reset_data got %h/%h want 0/0", pldata_a, prdata_a);
        end
        checks++;
        if ({lvalid_a, rvalid_a, frame_a, lvalid_b, rvalid_b, frame_b} !== 6'd0) begin
            errors++;
            $display("FAIL reset_strobes got %b%b%b%b%b%b want 000000",
                     lvalid_a, rvalid_a, frame_a, lvalid_b, rvalid_b, frame_b);
        end
    endtask

    task automatic test_basic_32();
        begin_test();
        send_word(1'b1, {$urandom(), $urandom()}, 32);
        send_word(1'b0, 64'hA5A50F0F, 32);
        send_word(1'b1, 64'h12345678, 32);
        flush();
        checks++;
        if (obs_l.size() - s_l !== 1 || obs_l[s_l] !== 32'hA5A50F0F) begin
            errors++;
            $display("FAIL basic_left got n=%0d %h want n=1 a5a50f0f", obs_l.size() - s_l, obs_l[s_l]);
        end
        checks++;
        if (obs_r.size() - s_r !== 2 || obs_r[s_r+1] !== 32'h12345678) begin
            errors++;
            $display("FAIL basic_right got n=%0d %h want n=2 12345678", obs_r.size() - s_r, obs_r[s_r+1]);
        end
        checks++;
        if ({obs_f[s_r], obs_f[s_r+1]} !== 2'b01 || fhigh - s_fh !== 1) begin
            errors++;
            $display("FAIL basic_frame got %b%b cycles=%0d want 01 cycles=1",
                     obs_f[s_r], obs_f[s_r+1], fhigh - s_fh);
        end
    endtask

    task automatic test_short_slots();
        begin_test();
        send_word(1'b1, {$urandom(), $urandom()}, 16);
        send_word(1'b0, 64'hBEEF, 16);
        send_word(1'b1, 64'h0001, 16);
        flush();
        checks++;
        if (pldata_a !== 32'hBEEF0000) begin
            errors++;
            $display("FAIL short_left got %h want beef0000", pldata_a);
        end
        checks++;
        if (prdata_a !== 32'h00010000) begin
            errors++;
            $display("FAIL short_right got %h want 00010000", prdata_a);
        end
    endtask

    task automatic test_truncate();
        begin_test();
        send_word(1'b1, {$urandom(), $urandom()}, 32);
        send_word(1'b0, 64'h89ABCDEF, 32);
        flush();
        checks++;
        if (pldata_b !== 24'h89ABCD || lcnt_b - s_b !== 1) begin
            errors++;
            $display("FAIL trunc_w24 got %h strobes=%0d want 89abcd strobes=1", pldata_b, lcnt_b - s_b);
        end
        checks++;
        if (pldata_a !== 32'h89ABCDEF) begin
            errors++;
            $display("FAIL trunc_w32 got %h want 89abcdef", pldata_a);
        end
    endtask

    task automatic test_mid_slot_release();
        logic [63:0] x, y, z;
        x = 64'($urandom_range(0, 65535));
        y = 64'($urandom_range(0, 65535));
        z = 64'($urandom_range(0, 65535));
        begin_test();
        for (int i = 0; i < 7; i++) drive(1'b0, 1'($urandom()));
        send_word(1'b1, x, 16);
        @(negedge clk);
        #1;
        checks++;
        if (obs_l.size() - s_l !== 0 || obs_r.size() - s_r !== 0) begin
            errors++;
            $display("FAIL presync_strobes got l=%0d r=%0d want 0/0", obs_l.size() - s_l, obs_r.size() - s_r);
        end
        send_word(1'b0, y, 16);
        send_word(1'b1, z, 16);
        flush();
        checks++;
        if (obs_r.size() - s_r !== 2 || obs_r[s_r] !== align(x, 16, 32) || obs_r[s_r+1] !== align(z, 16, 32)) begin
            errors++;
            $display("FAIL midrel_right got n=%0d %h %h want n=2 %h %h", obs_r.size() - s_r,
                     obs_r[s_r], obs_r[s_r+1], align(x, 16, 32), align(z, 16, 32));
        end
        checks++;
        if ({obs_f[s_r], obs_f[s_r+1]} !== 2'b01) begin
            errors++;
            $display("FAIL midrel_frame got %b%b want 01", obs_f[s_r], obs_f[s_r+1]);
        end
        checks++;
        if (obs_l.size() - s_l !== 1 || obs_l[s_l] !== align(y, 16, 32)) begin
            errors++;
            $display("FAIL midrel_left got n=%0d %h want n=1 %h", obs_l.size() - s_l, obs_l[s_l], align(y, 16, 32));
        end
    endtask

    task automatic test_reset_mid_word();
        logic [31:0] c, d;
        c = $urandom();
        d = $urandom();
        begin_test();
        send_word(1'b1, 64'($urandom()), 32);
        send_word(1'b0, 64'($urandom()), 32);
        send_word(1'b1, 64'($urandom()), 32);
        boundary_edge(1'b0);
        for (int i = 0; i < 9; i++) drive(1'b0, 1'($urandom()));
        rst = 1'b1;
        drive(1'b0, 1'($urandom()));
        rst = 1'b0;
        checks++;
        if ({pldata_a, prdata_a, lvalid_a, rvalid_a, frame_a} !== 67'd0) begin
            errors++;
            $display("FAIL midrst_zero got %h %h %b%b%b want all 0", pldata_a, prdata_a, lvalid_a, rvalid_a, frame_a);
        end
        model_reset();
        for (int i = 0; i < 5; i++) drive(1'b0, 1'($urandom()));
        send_word(1'b1, 64'($urandom()), 32);
        send_word(1'b0, 64'(c), 32);
        send_word(1'b1, 64'(d), 32);
        flush();
        checks++;
        if (obs_l.size() - s_l !== 1 || obs_l[s_l] !== c) begin
            errors++;
            $display("FAIL midrst_left got n=%0d %h want n=1 %h", obs_l.size() - s_l, obs_l[s_l], c);
        end
        checks++;
        if (obs_r.size() - s_r !== 2 || obs_r[s_r+1] !== d || {obs_f[s_r], obs_f[s_r+1]} !== 2'b01) begin
            errors++;
            $display("FAIL midrst_right got n=%0d %h f=%b%b want n=2 %h f=01", obs_r.size() - s_r,
                     obs_r[s_r+1], obs_f[s_r], obs_f[s_r+1], d);
        end
    endtask

    task automatic test_back_to_back();
        begin_test();
        send_word(1'b1, 64'($urandom()), 32);
        send_word(1'b0, 64'd1, 32);
        send_word(1'b1, 64'd2, 32);
        send_word(1'b0, 64'd3, 32);
        flush();
        checks++;
        if (obs_l.size() - s_l !== 2 || obs_l[s_l] !== 32'd1 || obs_l[s_l+1] !== 32'd3) begin
            errors++;
            $display("FAIL b2b_left got n=%0d %h %h want n=2 1 3", obs_l.size() - s_l, obs_l[s_l], obs_l[s_l+1]);
        end
        checks++;
        if (obs_lpr[s_l+1] !== 32'd2 || prdata_a !== 32'd2) begin
            errors++;
            $display("FAIL b2b_hold got %h/%h want 2/2", obs_lpr[s_l+1], prdata_a);
        end
        checks++;
        if (obs_r.size() - s_r !== 2 || fhigh - s_fh !== 1) begin
            errors++;
            $display("FAIL b2b_strobes got r=%0d f=%0d want r=2 f=1", obs_r.size() - s_r, fhigh - s_fh);
        end
    endtask

    task automatic test_random();
        int nf;
        begin_test();
        send_word(1'b1, {$urandom(), $urandom()}, $urandom_range(1, 40));
        for (int w = 0; w < 40; w++) begin
            send_word(1'(w % 2 == 1), {$urandom(), $urandom()}, $urandom_range(1, 40));
        end
        flush();
        checks++;
        if (obs_l.size() - s_l !== exp_l.size() || obs_r.size() - s_r !== exp_r.size()) begin
            errors++;
            $display("FAIL rand_counts got l=%0d r=%0d want l=%0d r=%0d",
                     obs_l.size() - s_l, obs_r.size() - s_r, exp_l.size(), exp_r.size());
        end
        for (int i = 0; i < exp_l.size(); i++) begin
            checks++;
            if (obs_l[s_l+i] !== exp_l[i]) begin
                errors++;
                $display("FAIL rand_left[%0d] got %h want %h", i, obs_l[s_l+i], exp_l[i]);
            end
        end
        nf = 0;
        for (int i = 0; i < exp_r.size(); i++) begin
            checks++;
            if (obs_r[s_r+i] !== exp_r[i] || obs_f[s_r+i] !== exp_f[i]) begin
                errors++;
                $display("FAIL rand_right[%0d] got %h f=%b want %h f=%b",
                         i, obs_r[s_r+i], obs_f[s_r+i], exp_r[i], exp_f[i]);
            end
            if (exp_f[i]) nf++;
        end
        checks++;
        if (fhigh - s_fh !== nf) begin
            errors++;
            $display("FAIL rand_frame_cycles got %0d want %0d", fhigh - s_fh, nf);
        end
    endtask

    initial begin
        test_reset();
        test_basic_32();
        test_short_slots();
        test_truncate();
        test_mid_slot_release();
        test_reset_mid_word();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
